// File: rtl/alu_pkg.sv
// Shared definitions for the BPF ALU: operation encoding and control width.
package alu_pkg;

    localparam int unsigned ALU_OP_W = 4;

    // Codes match the BPF opcode op field (upper nibble >> 4).
    typedef enum logic [ALU_OP_W-1:0] {
        ADD  = 4'h0,
        SUB  = 4'h1,
        MUL  = 4'h2,
        DIV  = 4'h3,
        OR   = 4'h4,
        AND  = 4'h5,
        LSH  = 4'h6,
        RSH  = 4'h7,
        NEG  = 4'h8,
        MOD  = 4'h9,
        XOR  = 4'hA,
        MOV  = 4'hB,
        ARSH = 4'hC
    } alu_op_t;

endpackage : alu_pkg

// File: rtl/alu_core.sv
// Combinational BPF ALU datapath: result and illegal flag from (a, b, ctl).
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [ALU_OP_W-1:0] ctl,
    output logic [WIDTH-1:0]    result_c,
    output logic                illegal_c
);

    localparam int unsigned SH_W = $clog2(WIDTH);

    // Shift amounts are taken modulo WIDTH; WIDTH is a power of two.
    logic [SH_W-1:0] shamt;
    assign shamt = b[SH_W-1:0];

    always_comb begin
        result_c  = '0;
        illegal_c = 1'b0;
        case (alu_op_t'(ctl))
            ADD:  result_c = a + b;
            SUB:  result_c = a - b;
            MUL:  result_c = a * b;
            DIV:  result_c = (b == '0) ? '0 : a / b;
            OR:   result_c = a | b;
            AND:  result_c = a & b;
            LSH:  result_c = a << shamt;
            RSH:  result_c = a >> shamt;
            NEG:  result_c = -a;
            MOD:  result_c = (b == '0) ? a : a % b;
            XOR:  result_c = a ^ b;
            MOV:  result_c = b;
            ARSH: result_c = $unsigned($signed(a) >>> shamt);
            default: illegal_c = 1'b1;
        endcase
    end

endmodule : alu_core

// File: rtl/alu.sv
// Registered BPF ALU: one-cycle latency, one operation per cycle, no backpressure.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [ALU_OP_W-1:0] ctl,
    input  logic                in_valid,
    output logic [WIDTH-1:0]    out,
    output logic                out_valid,
    output logic                illegal
);

    logic [WIDTH-1:0] result_c;
    logic             illegal_c;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a         (a),
        .b         (b),
        .ctl       (ctl),
        .result_c  (result_c),
        .illegal_c (illegal_c)
    );

    // Result and flag hold while idle; valid pulses only for accepted ops.
    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
            illegal   <= 1'b0;
        end else if (in_valid) begin
            out       <= result_c;
            out_valid <= 1'b1;
            illegal   <= illegal_c;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule : alu

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases plus randomized ops against an arithmetic model.
module tb_alu;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       ctl;
    logic             in_valid;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             illegal;

    int n_cmp  = 0;
    int n_fail = 0;

    alu #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .ctl       (ctl),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // Reference model in plain integer arithmetic modulo 256.
    function automatic void ref_op(input int av, input int bv, input int c,
                                   output int r, output bit ill);
        int s;
        int sa;
        int p;
        s   = bv % 8;
        p   = 1 << s;
        ill = 1'b0;
        r   = 0;
        case (c)
            0:  r = (av + bv) % 256;
            1:  r = (av - bv + 256) % 256;
            2:  r = (av * bv) % 256;
            3:  r = (bv == 0) ? 0 : av / bv;
            4:  r = av | bv;
            5:  r = av & bv;
            6:  r = (av * p) % 256;
            7:  r = av / p;
            8:  r = (256 - av) % 256;
            9:  r = (bv == 0) ? av : av % bv;
            10: r = av ^ bv;
            11: r = bv;
            12: begin
                sa = (av >= 128) ? av - 256 : av;
                sa = (sa < 0) ? (sa - (p - 1)) / p : sa / p;
                r  = (sa + 256) % 256;
            end
            default: begin r = 0; ill = 1'b1; end
        endcase
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ctl = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (out !== 8'd0 || out_valid !== 1'b0 || illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: out=%0d v=%b ill=%b, need 0/0/0", out, out_valid, illegal);
        end
        rst = 1'b0;
    endtask

    task automatic test_or_first();
        a = 8'd20; b = 8'd4; ctl = 4'h4; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out !== 8'd20 || out_valid !== 1'b1 || illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL or_first: out=%0d v=%b ill=%b, need 20/1/0", out, out_valid, illegal);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ta [4] = '{8'd20, 8'd4, 8'd20, 8'd20};
        logic [7:0] tb [4] = '{8'd4, 8'd20, 8'd20, 8'd0};
        logic [3:0] tc [4] = '{4'h0, 4'h1, 4'h2, 4'h8};
        logic [7:0] te [4] = '{8'd24, 8'd240, 8'd144, 8'd236};
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) begin
                n_cmp++;
                if (out !== te[i-1] || out_valid !== 1'b1 || illegal !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b[%0d]: out=%0d v=%b ill=%b, need %0d/1/0",
                             i-1, out, out_valid, illegal, te[i-1]);
                end
            end
            if (i < 4) begin
                a = ta[i]; b = tb[i]; ctl = tc[i]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (out_valid !== 1'b0 || out !== 8'd236) begin
            n_fail++;
            $display("FAIL b2b_idle: out=%0d v=%b, need 236/0", out, out_valid);
        end
    endtask

    // Directed single ops with spec-given expected values.
    task automatic test_directed();
        logic [7:0] ta [11] = '{8'd20, 8'd20, 8'd20, 8'd20, 8'h81, 8'h80, 8'h80, 8'h40, 8'hF0, 8'h00, 8'h33};
        logic [7:0] tb [11] = '{8'd4,  8'd0,  8'd6,  8'd0,  8'd9,  8'd1,  8'd1,  8'd3,  8'h3C, 8'h5A, 8'h44};
        logic [3:0] tc [11] = '{4'h3,  4'h3,  4'h9,  4'h9,  4'h6,  4'h7,  4'hC,  4'hC,  4'hA,  4'hB,  4'hE};
        logic [7:0] te [11] = '{8'd5,  8'd0,  8'd2,  8'd20, 8'h02, 8'h40, 8'hC0, 8'h08, 8'hCC, 8'h5A, 8'h00};
        logic       ti [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 11; i++) begin
            a = ta[i]; b = tb[i]; ctl = tc[i]; in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            n_cmp++;
            if (out !== te[i] || out_valid !== 1'b1 || illegal !== ti[i]) begin
                n_fail++;
                $display("FAIL directed[%0d] ctl=%h: out=%h v=%b ill=%b, need %h/1/%b",
                         i, tc[i], out, out_valid, illegal, te[i], ti[i]);
            end
        end
    endtask

    task automatic test_rst_priority();
        a = 8'h11; b = 8'h5A; ctl = 4'hB; in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b1; a = 8'd20; b = 8'd4; ctl = 4'h0;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if (out !== 8'd0 || out_valid !== 1'b0 || illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_priority: out=%0d v=%b ill=%b, need 0/0/0", out, out_valid, illegal);
        end
    endtask

    task automatic test_hold();
        a = 8'h81; b = 8'd9; ctl = 4'h6; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom); b = 8'($urandom); ctl = 4'($urandom);
            @(negedge clk);
            n_cmp++;
            if (out !== 8'h02 || out_valid !== 1'b0 || illegal !== 1'b0) begin
                n_fail++;
                $display("FAIL hold[%0d]: out=%h v=%b ill=%b, need 02/0/0", i, out, out_valid, illegal);
            end
        end
    endtask

    task automatic test_random();
        int  e_out = 8'h02;
        bit  e_ill = 1'b0;
        bit  e_v   = 1'b0;
        int  r;
        bit  ill;
        for (int i = 0; i < 400; i++) begin
            if (i > 0) begin
                n_cmp++;
                if (out !== 8'(e_out) || out_valid !== e_v || illegal !== e_ill) begin
                    n_fail++;
                    $display("FAIL random[%0d]: out=%h v=%b ill=%b, need %h/%b/%b",
                             i, out, out_valid, illegal, 8'(e_out), e_v, e_ill);
                end
            end
            a = 8'($urandom); b = 8'($urandom); ctl = 4'($urandom);
            if ($urandom_range(7) == 0) b = 8'd0;
            in_valid = ($urandom_range(3) != 0);
            ref_op(int'(a), int'(b), int'(ctl), r, ill);
            e_v = in_valid;
            if (in_valid) begin
                e_out = r; e_ill = ill;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ctl = '0;
        test_reset();
        test_or_first();
        test_back_to_back();
        test_directed();
        test_rst_priority();
        test_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_alu
